// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the small accumulator-less register CPU.
//   - stage_e  : one encoding for the five pipeline-less execution stages
//   - OP_*     : 4-bit opcode constants found in the top nibble of word A
//   - alu_op_e : operation select for the alu_p sub-module
//   - is_illegal_op : opcodes reserved but not defined (executed as NOP)
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_FETCHA = 3'd1,
        ST_FETCHB = 3'd2,
        ST_EXECA  = 3'd3,
        ST_EXECB  = 3'd4
    } stage_e;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_LD  = 4'd2;
    localparam logic [3:0] OP_ST  = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_JMP = 4'd8;
    localparam logic [3:0] OP_JZ  = 4'd9;
    localparam logic [3:0] OP_JC  = 4'd10;
    localparam logic [3:0] OP_HLT = 4'd15;

    // The ALU opcodes 4..7 map directly onto the low two opcode bits.
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'd11) && (op <= 4'd14);
    endfunction

endpackage

// File: rtl/alu_p.sv
// ---------------------------------------------------------------------------
// alu_p
// Purely combinational DW-bit ALU used by cpu_core.
// Ports:
//   op     in  alu_op_e  ADD / SUB / AND / OR select
//   a, b   in  DW        operands (a = rd value, b = rs value)
//   result out DW        operation result (ADD/SUB wrap modulo 2^DW)
//   carry  out 1         ADD: carry out; SUB: borrow (a < b unsigned); AND/OR: 0
//   zero   out 1         result == 0
// ---------------------------------------------------------------------------
module alu_p
    import cpu_pkg::*;
#(
    parameter int DW = 8
) (
    input  alu_op_e       op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero
);

    logic [DW:0] sum_ext;

    // The extended sum gives the ADD carry for free; SUB borrow is the plain
    // unsigned compare so it does not depend on two's-complement tricks.
    always_comb begin
        sum_ext = {1'b0, a} + {1'b0, b};
        result  = '0;
        carry   = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum_ext[DW-1:0];
                carry  = sum_ext[DW];
            end
            ALU_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/cpu_core.sv
// ---------------------------------------------------------------------------
// cpu_core
// Multi-cycle two-word-instruction CPU. Every instruction is fetched as
// word A (opcode in the top nibble, rd in the low bits) and word B (rs,
// immediate or address), then executed in EXECA (memory access for LD/ST
// only) and EXECB (writeback, flags, branches, halting).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   run                   leave WAIT (only while halt is low)
//   halt                  stop at the end of the current instruction
//   mem_req/mem_we        access request / write strobe, held until mem_ack
//   mem_addr/mem_wdata    access address / store data, held until mem_ack
//   mem_rdata/mem_ack     read data (valid with ack) / access completion
//   pc_out                program counter
//   waits..execb          one-hot stage indicators
//   cflag, zflag          carry/borrow and zero flags
//   illegal               one-cycle pulse in EXECB for opcodes 11..14
// ---------------------------------------------------------------------------
module cpu_core
    import cpu_pkg::*;
#(
    parameter int DW   = 8,
    parameter int AW   = 8,
    parameter int NREG = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          halt,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [AW-1:0] pc_out,
    output logic          waits,
    output logic          fetcha,
    output logic          fetchb,
    output logic          execa,
    output logic          execb,
    output logic          cflag,
    output logic          zflag,
    output logic          illegal
);

    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

    stage_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] word_a_q, word_a_d;
    logic [DW-1:0] word_b_q, word_b_d;
    logic [DW-1:0] ld_data_q, ld_data_d;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic          cflag_q, cflag_d;
    logic          zflag_q, zflag_d;
    logic          halt_pend_q, halt_pend_d;

    logic [3:0]    opcode;
    logic [RW-1:0] rd_idx;
    logic [RW-1:0] rs_idx;
    logic [DW-1:0] rd_val;
    logic [DW-1:0] rs_val;
    logic          is_mem_op;
    logic [DW-1:0] alu_result;
    logic          alu_carry;
    logic          alu_zero;

    assign opcode    = word_a_q[DW-1:DW-4];
    assign rd_idx    = word_a_q[RW-1:0];
    assign rs_idx    = word_b_q[RW-1:0];
    assign rd_val    = regs_q[rd_idx];
    assign rs_val    = regs_q[rs_idx];
    assign is_mem_op = (opcode == OP_LD) || (opcode == OP_ST);

    // Word A bits between the register field and the opcode carry no meaning.
    generate
        if (DW - 4 > RW) begin : g_spare_bits
            logic unused_word_a_bits;
            assign unused_word_a_bits = ^word_a_q[DW-5:RW];
        end
    endgenerate

    alu_p #(
        .DW(DW)
    ) u_alu (
        .op     (alu_op_e'(opcode[1:0])),
        .a      (rd_val),
        .b      (rs_val),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Memory interface is decoded from the registered state and words only,
    // so address/strobe/data cannot move while an access waits for mem_ack.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = rd_val;
        case (state_q)
            ST_FETCHA, ST_FETCHB: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end
            ST_EXECA: begin
                mem_req  = is_mem_op;
                mem_we   = (opcode == OP_ST);
                mem_addr = word_b_q[AW-1:0];
            end
            default: begin
                mem_req = 1'b0;
                mem_we  = 1'b0;
            end
        endcase
    end

    assign pc_out  = pc_q;
    assign waits   = (state_q == ST_WAIT);
    assign fetcha  = (state_q == ST_FETCHA);
    assign fetchb  = (state_q == ST_FETCHB);
    assign execa   = (state_q == ST_EXECA);
    assign execb   = (state_q == ST_EXECB);
    assign cflag   = cflag_q;
    assign zflag   = zflag_q;
    // EXECB always lasts exactly one cycle, which makes this a single pulse.
    assign illegal = (state_q == ST_EXECB) && is_illegal_op(opcode);

    // Next-state and datapath updates. A halt request is remembered from any
    // cycle and only acted upon when the current instruction has retired.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        word_a_d    = word_a_q;
        word_b_d    = word_b_q;
        ld_data_d   = ld_data_q;
        regs_d      = regs_q;
        cflag_d     = cflag_q;
        zflag_d     = zflag_q;
        halt_pend_d = halt_pend_q | halt;

        case (state_q)
            ST_WAIT: begin
                if (run && !halt) begin
                    state_d = ST_FETCHA;
                end
            end
            ST_FETCHA: begin
                if (mem_ack) begin
                    word_a_d = mem_rdata;
                    pc_d     = pc_q + AW'(1);
                    state_d  = ST_FETCHB;
                end
            end
            ST_FETCHB: begin
                if (mem_ack) begin
                    word_b_d = mem_rdata;
                    pc_d     = pc_q + AW'(1);
                    state_d  = ST_EXECA;
                end
            end
            ST_EXECA: begin
                if (!is_mem_op) begin
                    state_d = ST_EXECB;
                end else if (mem_ack) begin
                    if (opcode == OP_LD) begin
                        ld_data_d = mem_rdata;
                    end
                    state_d = ST_EXECB;
                end
            end
            ST_EXECB: begin
                case (opcode)
                    OP_LDI: regs_d[rd_idx] = word_b_q;
                    OP_LD:  regs_d[rd_idx] = ld_data_q;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        regs_d[rd_idx] = alu_result;
                        cflag_d        = alu_carry;
                        zflag_d        = alu_zero;
                    end
                    OP_JMP: pc_d = word_b_q[AW-1:0];
                    OP_JZ: begin
                        if (zflag_q) begin
                            pc_d = word_b_q[AW-1:0];
                        end
                    end
                    OP_JC: begin
                        if (cflag_q) begin
                            pc_d = word_b_q[AW-1:0];
                        end
                    end
                    default: begin
                        pc_d = pc_q;
                    end
                endcase

                if (halt_pend_q || halt || (opcode == OP_HLT)) begin
                    state_d     = ST_WAIT;
                    halt_pend_d = 1'b0;
                end else begin
                    state_d = ST_FETCHA;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // State register. Reset wins over everything, so an access still waiting
    // for mem_ack is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            pc_q        <= '0;
            word_a_q    <= '0;
            word_b_q    <= '0;
            ld_data_q   <= '0;
            regs_q      <= '{default: '0};
            cflag_q     <= 1'b0;
            zflag_q     <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            word_a_q    <= word_a_d;
            word_b_q    <= word_b_d;
            ld_data_q   <= ld_data_d;
            regs_q      <= regs_d;
            cflag_q     <= cflag_d;
            zflag_q     <= zflag_d;
            halt_pend_q <= halt_pend_d;
        end
    end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 SHALL use one clock `clk` and a synchronous, active-high reset `rst`; all state updates on rising `clk`.
REQ-002 SHALL have parameter DW, default 8: data/instruction word width, >= 8.
REQ-003 SHALL have parameter AW, default 8: address width, <= DW.
REQ-004 SHALL have parameter NREG, default 16: register count, power of 2, <= 2^(DW-4).
REQ-005 SHALL have port clk  in  1  clock.
REQ-006 SHALL have port rst  in  1  sync active-high reset.
REQ-007 SHALL have port run  in  1  start execution from WAIT.
REQ-008 SHALL have port halt  in  1  request stop at the next instruction boundary.
REQ-009 SHALL have port mem_req  out  1  memory access request.
REQ-010 SHALL have port mem_we  out  1  write (1) / read (0), valid with mem_req.
REQ-011 SHALL have port mem_addr  out  AW  access address.
REQ-012 SHALL have port mem_wdata  out  DW  store data.
REQ-013 SHALL have port mem_rdata  in  DW  read data, valid in the mem_ack cycle.
REQ-014 SHALL have port mem_ack  in  1  access completes this cycle.
REQ-015 SHALL have port pc_out  out  AW  program counter.
REQ-016 SHALL have ports waits, fetcha, fetchb, execa, execb  out  1 each  one-hot stage indicators.
REQ-017 SHALL have ports cflag, zflag  out  1  carry/borrow flag and zero flag.
REQ-018 SHALL have port illegal  out  1  one-cycle pulse on an undefined opcode.

Function
REQ-019 SHALL sequence WAIT->FETCHA->FETCHB->EXECA->EXECB->FETCHA; WAIT->FETCHA only when run=1 and halt=0.
REQ-020 SHALL hold mem_req=1 with mem_addr/mem_we/mem_wdata stable until mem_ack, stall the state until then, and ignore mem_ack when mem_req=0.
REQ-021 SHALL in FETCHA read M[pc] into word A {op[3:0] at the top, rd in the low bits}; FETCHB reads M[pc] into word B (rs, immediate or address in the low bits); pc increments mod 2^AW on each fetch ack.
REQ-022 SHALL decode opcodes 0 NOP, 1 LDI rd=B, 2 LD rd=M[B], 3 ST M[B]=rd, 4 ADD, 5 SUB, 6 AND, 7 OR (rd=rd op rs), 8 JMP, 9 JZ, 10 JC (pc=B[AW-1:0] when the condition holds), 15 HLT.
REQ-023 SHALL make memory accesses in EXECA only for LD/ST; every other opcode leaves EXECA after 1 cycle.
REQ-024 SHALL perform register writeback and flag update in EXECB, after which the next stage is FETCHA.
REQ-025 SHALL compute ADD with DW-bit modulo wrap, cflag = carry out; SUB with cflag = (rd<rs) unsigned; AND/OR clear cflag; zflag = (result==0) for opcodes 4-7 only.
REQ-026 SHALL leave flags unchanged for all other opcodes.
REQ-027 SHALL treat opcodes 11-14 as NOP and pulse illegal in EXECB.
REQ-028 SHALL latch halt at any cycle into halt_pend; at EXECB exit, halt_pend=1 or HLT goes to WAIT and clears halt_pend; run in WAIT then resumes at the current pc.
REQ-029 SHALL let a branch taken in EXECB override the fetch increments; the next FETCHA uses the target.
REQ-030 SHALL set illegal=0 outside its pulse.

Reset
REQ-031 SHALL on rst=1 at a clock edge, including mid-access, force state WAIT, pc=0, all registers=0, cflag=zflag=0, mem_req=0, mem_we=0, halt_pend=0, illegal=0; an outstanding access is abandoned.
REQ-032 SHALL drive waits=1 and all other stage outputs 0 after reset.

Structure
REQ-033 SHALL place opcode constants and the stage encoding in shared package cpu_pkg.
REQ-034 SHALL instantiate one sub-module, alu_p (parametrised DW; ADD/SUB/AND/OR, carry and zero out); the register file stays an internal array.

Verification
REQ-035 SHALL check that with mem_ack=1 every cycle, LDI r1,5; LDI r2,3; ADD r1,r2 gives r1=8, cflag=0, zflag=0, and each instruction takes 4 cycles.
REQ-036 SHALL check that DW=8 with r1=0xFF and r2=0x01 ADD gives r1=0x00, cflag=1, zflag=1; a following JC 0x20 gives pc=0x20.
REQ-037 SHALL check that with mem_ack delayed 3 cycles on every access, ST r1,0x40 holds mem_req/mem_addr=0x40/mem_we=1 stable for 4 cycles and the stage stays EXECA.
REQ-038 SHALL check that halt pulsed for 1 cycle during FETCHB completes the current instruction and reaches WAIT; run then resumes at the next pc.
REQ-039 SHALL check that rst asserted during an LD wait state gives WAIT, pc=0 and mem_req=0 the next cycle; opcode 12 pulses illegal for 1 cycle with state unchanged.
